// File: rtl/sparse_pair_selector.sv
// Sparse pair selector: buffers one chunk of IFM/filter sparse beats, then emits matched byte pairs.
// Optional accumulator outputs acc_o/acc_valid_o are enabled by defining SPARSE_SEL_ACC_EN.
module sparse_pair_selector #(
    parameter int CHUNK_SIZE = 128,
    parameter int BUS_SIZE   = 8,
    parameter int LANES      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [BUS_SIZE-1:0]   ifm_sparsemap_i,
    input  logic [BUS_SIZE*8-1:0] ifm_nonzero_data_i,
    input  logic                  ifm_wr_valid_i,
    output logic                  ifm_wr_ready_o,
    input  logic [BUS_SIZE-1:0]   filter_sparsemap_i,
    input  logic [BUS_SIZE*8-1:0] filter_nonzero_data_i,
    input  logic                  filter_wr_valid_i,
    output logic                  filter_wr_ready_o,
    output logic [LANES*8-1:0]    ifm_data_o,
    output logic [LANES*8-1:0]    filter_data_o,
    output logic [LANES-1:0]      lane_valid_o,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic                  chunk_end_o
`ifdef SPARSE_SEL_ACC_EN
   ,output logic [31:0]           acc_o,
    output logic                  acc_valid_o
`endif
);
    localparam int NWIN = CHUNK_SIZE / BUS_SIZE;
    localparam int CW   = $clog2(NWIN + 1);
    localparam int WW   = (NWIN > 1) ? $clog2(NWIN) : 1;

    typedef enum logic {FILL, SCAN} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          icnt_q, icnt_d, fcnt_q, fcnt_d;
    logic [WW-1:0]          win_q, win_d;
    logic [BUS_SIZE-1:0]    mask_q, mask_d;
    logic                   fresh_q, fresh_d, done_q, done_d, rdy_en_q;
    logic                   dv_q, dv_d, ce_q, ce_d;
    logic [LANES-1:0]       lv_q, lv_d;
    logic [LANES*8-1:0]     odi_q, odi_d, odf_q, odf_d;

    logic [CHUNK_SIZE-1:0]   imap_q, fmap_q;
    logic [CHUNK_SIZE*8-1:0] imem_q, fmem_q;

    logic [BUS_SIZE*8-1:0]  ibeat, fbeat;
    logic                   ifm_we, flt_we, can_load, xfer, last_win;
    logic [BUS_SIZE-1:0]    cur_mask, picked, rem;
    logic [LANES-1:0]       pk_lv;
    logic [LANES*8-1:0]     pk_i, pk_f;

    assign ifm_wr_ready_o    = rdy_en_q && (state_q == FILL) && (icnt_q < CW'(NWIN));
    assign filter_wr_ready_o = rdy_en_q && (state_q == FILL) && (fcnt_q < CW'(NWIN));
    assign ifm_we            = ifm_wr_valid_i && ifm_wr_ready_o;
    assign flt_we            = filter_wr_valid_i && filter_wr_ready_o;

    // Expand packed nonzero bytes onto their dense positions.
    always_comb begin
        int unsigned ij;
        int unsigned fj;
        ibeat = '0;
        fbeat = '0;
        ij    = 0;
        fj    = 0;
        for (int unsigned p = 0; p < BUS_SIZE; p++) begin
            if (ifm_sparsemap_i[p]) begin
                ibeat[p*8 +: 8] = ifm_nonzero_data_i[ij*8 +: 8];
                ij++;
            end
            if (filter_sparsemap_i[p]) begin
                fbeat[p*8 +: 8] = filter_nonzero_data_i[fj*8 +: 8];
                fj++;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (ifm_we) begin
            imap_q[icnt_q*BUS_SIZE +: BUS_SIZE]       <= ifm_sparsemap_i;
            imem_q[icnt_q*(BUS_SIZE*8) +: BUS_SIZE*8] <= ibeat;
        end
        if (flt_we) begin
            fmap_q[fcnt_q*BUS_SIZE +: BUS_SIZE]       <= filter_sparsemap_i;
            fmem_q[fcnt_q*(BUS_SIZE*8) +: BUS_SIZE*8] <= fbeat;
        end
    end

    assign cur_mask = fresh_q ? (imap_q[win_q*BUS_SIZE +: BUS_SIZE] & fmap_q[win_q*BUS_SIZE +: BUS_SIZE])
                              : mask_q;
    assign last_win = (win_q == WW'(NWIN - 1));
    assign can_load = !dv_q || data_ready_i;
    assign xfer     = dv_q && data_ready_i;
    assign rem      = cur_mask & ~picked;

    always_comb begin
        int unsigned n;
        pk_i   = '0;
        pk_f   = '0;
        pk_lv  = '0;
        picked = '0;
        n      = 0;
        for (int unsigned p = 0; p < BUS_SIZE; p++) begin
            if (cur_mask[p] && n < LANES) begin
                pk_i[n*8 +: 8] = imem_q[(win_q*BUS_SIZE + p)*8 +: 8];
                pk_f[n*8 +: 8] = fmem_q[(win_q*BUS_SIZE + p)*8 +: 8];
                pk_lv[n +: 1]  = 1'b1;
                picked[p]      = 1'b1;
                n++;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        fcnt_d  = fcnt_q;
        win_d   = win_q;
        mask_d  = mask_q;
        fresh_d = fresh_q;
        done_d  = done_q;
        dv_d    = dv_q;
        ce_d    = ce_q;
        lv_d    = lv_q;
        odi_d   = odi_q;
        odf_d   = odf_q;
        case (state_q)
            FILL: begin
                if (ifm_we) icnt_d = icnt_q + 1'b1;
                if (flt_we) fcnt_d = fcnt_q + 1'b1;
                if (icnt_q == CW'(NWIN) && fcnt_q == CW'(NWIN)) begin
                    state_d = SCAN;
                    win_d   = '0;
                    fresh_d = 1'b1;
                    done_d  = 1'b0;
                end
            end
            SCAN: begin
                if (xfer && ce_q) begin
                    state_d = FILL;
                    icnt_d  = '0;
                    fcnt_d  = '0;
                end
                if (can_load) begin
                    dv_d  = 1'b0;
                    ce_d  = 1'b0;
                    lv_d  = '0;
                    odi_d = '0;
                    odf_d = '0;
                    // An empty non-final window costs one cycle; an empty final window still emits the end beat.
                    if (!done_q) begin
                        if (cur_mask == '0 && !last_win) begin
                            win_d   = win_q + 1'b1;
                            fresh_d = 1'b1;
                        end else begin
                            dv_d  = 1'b1;
                            lv_d  = pk_lv;
                            odi_d = pk_i;
                            odf_d = pk_f;
                            ce_d  = last_win && (rem == '0);
                            if (rem != '0) begin
                                mask_d  = rem;
                                fresh_d = 1'b0;
                            end else if (last_win) begin
                                done_d = 1'b1;
                            end else begin
                                win_d   = win_q + 1'b1;
                                fresh_d = 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= FILL;
            icnt_q   <= '0;
            fcnt_q   <= '0;
            win_q    <= '0;
            mask_q   <= '0;
            fresh_q  <= 1'b0;
            done_q   <= 1'b0;
            rdy_en_q <= 1'b0;
            dv_q     <= 1'b0;
            ce_q     <= 1'b0;
            lv_q     <= '0;
            odi_q    <= '0;
            odf_q    <= '0;
        end else begin
            state_q  <= state_d;
            icnt_q   <= icnt_d;
            fcnt_q   <= fcnt_d;
            win_q    <= win_d;
            mask_q   <= mask_d;
            fresh_q  <= fresh_d;
            done_q   <= done_d;
            rdy_en_q <= 1'b1;
            dv_q     <= dv_d;
            ce_q     <= ce_d;
            lv_q     <= lv_d;
            odi_q    <= odi_d;
            odf_q    <= odf_d;
        end
    end

    assign ifm_data_o    = odi_q;
    assign filter_data_o = odf_q;
    assign lane_valid_o  = lv_q;
    assign data_valid_o  = dv_q;
    assign chunk_end_o   = ce_q;

`ifdef SPARSE_SEL_ACC_EN
    logic [31:0] acc_q, prod;
    logic        acc_vld_q;

    always_comb begin
        prod = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (lv_q[l]) prod = prod + 32'(odi_q[l*8 +: 8]) * 32'(odf_q[l*8 +: 8]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q     <= '0;
            acc_vld_q <= 1'b0;
        end else begin
            acc_vld_q <= xfer && ce_q;
            if (state_q == FILL && state_d == SCAN) acc_q <= '0;
            else if (xfer)                          acc_q <= acc_q + prod;
        end
    end

    assign acc_o       = acc_q;
    assign acc_valid_o = acc_vld_q;
`endif
endmodule

// File: tb/tb_sparse_pair_selector.sv
// Self-checking bench for sparse_pair_selector (CHUNK_SIZE=16, BUS_SIZE=8, LANES=2).
module tb_sparse_pair_selector;
    logic        clk, rst_n;
    logic [7:0]  ifm_map, flt_map;
    logic [63:0] ifm_dat, flt_dat;
    logic        ifm_v, flt_v, ifm_r, flt_r;
    logic [15:0] ifm_o, flt_o;
    logic [1:0]  lv_o;
    logic        dv_o, dr, ce_o;

    sparse_pair_selector #(.CHUNK_SIZE(16), .BUS_SIZE(8), .LANES(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ifm_sparsemap_i(ifm_map), .ifm_nonzero_data_i(ifm_dat),
        .ifm_wr_valid_i(ifm_v), .ifm_wr_ready_o(ifm_r),
        .filter_sparsemap_i(flt_map), .filter_nonzero_data_i(flt_dat),
        .filter_wr_valid_i(flt_v), .filter_wr_ready_o(flt_r),
        .ifm_data_o(ifm_o), .filter_data_o(flt_o), .lane_valid_o(lv_o),
        .data_valid_o(dv_o), .data_ready_i(dr), .chunk_end_o(ce_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  im0, im1, fm0, fm1;
        logic [63:0] ib0, ib1, fb0, fb1;
        int          exp_beats;
    } vec_t;

    typedef struct {
        logic [15:0] i, f;
        logic [1:0]  lv;
        logic        ce;
    } beat_t;

    beat_t exp_q[$];
    vec_t  vecs[5];
    int    total = 0;
    int    bad = 0;
    int    beats_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: decompress both streams, then emit matched positions two at a time per window.
    task automatic push_model(input vec_t v);
        logic [7:0]  di[16], df[16];
        logic [7:0]  im[2], fm[2];
        logic [63:0] ib[2], fb[2];
        int          pos[$];
        int          j, k;
        beat_t       b;
        im[0] = v.im0; im[1] = v.im1; fm[0] = v.fm0; fm[1] = v.fm1;
        ib[0] = v.ib0; ib[1] = v.ib1; fb[0] = v.fb0; fb[1] = v.fb1;
        for (int w = 0; w < 2; w++) begin
            j = 0;
            for (int p = 0; p < 8; p++) begin
                if (im[w][p]) begin di[w*8+p] = ib[w][j*8 +: 8]; j++; end
                else di[w*8+p] = 8'h00;
            end
            j = 0;
            for (int p = 0; p < 8; p++) begin
                if (fm[w][p]) begin df[w*8+p] = fb[w][j*8 +: 8]; j++; end
                else df[w*8+p] = 8'h00;
            end
        end
        for (int w = 0; w < 2; w++) begin
            pos.delete();
            for (int p = 0; p < 8; p++)
                if (im[w][p] && fm[w][p]) pos.push_back(w*8 + p);
            if (pos.size() == 0) begin
                if (w == 1) begin
                    b.i = 16'h0; b.f = 16'h0; b.lv = 2'b00; b.ce = 1'b1;
                    exp_q.push_back(b);
                end
            end else begin
                for (k = 0; k < pos.size(); k += 2) begin
                    b.i = {8'h00, di[pos[k]]}; b.f = {8'h00, df[pos[k]]}; b.lv = 2'b01;
                    if (k + 1 < pos.size()) begin
                        b.i[15:8] = di[pos[k+1]]; b.f[15:8] = df[pos[k+1]]; b.lv = 2'b11;
                    end
                    b.ce = (w == 1) && (k + 2 >= pos.size());
                    exp_q.push_back(b);
                end
            end
        end
    endtask

    // Called at a falling edge; the write completes on the next rising edge with ready high.
    task automatic wr(input bit flt, input logic [7:0] m, input logic [63:0] d);
        int n = 0;
        if (!flt) begin ifm_map = m; ifm_dat = d; ifm_v = 1'b1; end
        else      begin flt_map = m; flt_dat = d; flt_v = 1'b1; end
        while (!(flt ? flt_r : ifm_r) && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL wr_timeout actual=%0d required<50", n);
        end
        @(negedge clk);
        ifm_v = 1'b0; flt_v = 1'b0;
    endtask

    task automatic load(input vec_t v);
        wr(1'b0, v.im0, v.ib0);
        wr(1'b0, v.im1, v.ib1);
        wr(1'b1, v.fm0, v.fb0);
        wr(1'b1, v.fm1, v.fb1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL %s_timeout actual=%0d required=0 pending", name, exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_beats(input int target);
        int n = 0;
        while (beats_seen < target && n < 300) begin @(negedge clk); #1; n++; end
        if (n >= 300) begin
            total++; bad++;
            $display("FAIL wait_beats actual=%0d required=%0d", beats_seen, target);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        #2;
        if (rst_n && dv_o && dr) begin
            total++;
            beats_seen++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL beat_extra actual=i%h f%h lv%b ce%b required=none", ifm_o, flt_o, lv_o, ce_o);
            end else begin
                e = exp_q.pop_front();
                if (ifm_o !== e.i || flt_o !== e.f || lv_o !== e.lv || ce_o !== e.ce) begin
                    bad++;
                    $display("FAIL beat actual=i%h f%h lv%b ce%b required=i%h f%h lv%b ce%b",
                             ifm_o, flt_o, lv_o, ce_o, e.i, e.f, e.lv, e.ce);
                end
            end
        end
    end

    initial begin
        logic [63:0] snap;
        vecs[0] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 64'h0807060504030201, 64'h100F0E0D0C0B0A09,
                    64'h0202020202020202, 64'h0202020202020202, 8};
        vecs[1] = '{8'h55, 8'h55, 8'hAA, 8'hAA, 64'h44332211, 64'h88776655,
                    64'h11223344, 64'h55667788, 1};
        vecs[2] = '{8'h81, 8'h00, 8'hFF, 8'hFF, 64'h0703, 64'h0,
                    64'h0101010101010101, 64'h0101010101010101, 2};
        vecs[3] = '{8'h07, 8'hF0, 8'h05, 8'hB0, 64'h00C0B0A0, 64'hD4D3D2D1,
                    64'h0E0D, 64'h00031211, 3};
        vecs[4] = '{8'h0F, 8'h3C, 8'hF0, 8'h0C, 64'h04030201, 64'h0C0B0A09,
                    64'hFFFEFDFC, 64'h0605, 1};

        rst_n = 1'b0; dr = 1'b1;
        ifm_v = 1'b0; flt_v = 1'b0; ifm_map = '0; flt_map = '0; ifm_dat = '0; flt_dat = '0;
        repeat (3) @(negedge clk);
        chk("rst_dv", dv_o, 0);
        chk("rst_ce", ce_o, 0);
        chk("rst_lv", lv_o, 0);
        chk("rst_data", {ifm_o, flt_o}, 0);
        chk("rst_rdy", {ifm_r, flt_r}, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_rst", {ifm_r, flt_r}, 2'b11);

        foreach (vecs[v]) begin
            push_model(vecs[v]);
            beats_seen = 0;
            load(vecs[v]);
            drain("vec");
            chk($sformatf("vec%0d_beats", v), beats_seen, vecs[v].exp_beats);
        end

        // Load skew: IFM finishes first, filter must still be accepted, no output yet.
        push_model(vecs[0]);
        beats_seen = 0;
        wr(1'b0, vecs[0].im0, vecs[0].ib0);
        wr(1'b0, vecs[0].im1, vecs[0].ib1);
        repeat (3) begin
            chk("skew_rdy", {ifm_r, flt_r}, 2'b01);
            chk("skew_dv", dv_o, 0);
            @(negedge clk);
        end
        wr(1'b1, vecs[0].fm0, vecs[0].fb0);
        wr(1'b1, vecs[0].fm1, vecs[0].fb1);
        drain("skew");
        chk("skew_beats", beats_seen, 8);

        // Backpressure: five stalled cycles after the second beat.
        push_model(vecs[0]);
        beats_seen = 0;
        load(vecs[0]);
        wait_beats(2);
        dr = 1'b0;
        snap = {28'h0, dv_o, lv_o, ce_o, ifm_o, flt_o};
        chk("bp_valid", dv_o, 1);
        repeat (5) begin
            @(negedge clk); #1;
            chk("bp_hold", {28'h0, dv_o, lv_o, ce_o, ifm_o, flt_o}, snap);
        end
        dr = 1'b1;
        drain("bp");
        chk("bp_beats", beats_seen, 8);

        // Reset during SCAN after the third beat, then a clean dense chunk.
        push_model(vecs[0]);
        beats_seen = 0;
        load(vecs[0]);
        wait_beats(3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dv", dv_o, 0);
        chk("mid_rst_lv", lv_o, 0);
        chk("mid_rst_ce", ce_o, 0);
        chk("mid_rst_data", {ifm_o, flt_o}, 0);
        chk("mid_rst_rdy", {ifm_r, flt_r}, 0);
        exp_q.delete();
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_rdy_rise", {ifm_r, flt_r}, 2'b11);
        push_model(vecs[0]);
        beats_seen = 0;
        load(vecs[0]);
        drain("post_rst");
        chk("post_rst_beats", beats_seen, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/sparse_pair_selector.md
SPARSE_PAIR_SELECTOR -- requirements
Module: sparse_pair_selector

Interface
REQ-001 Parameters SHALL be (name, default, meaning): CHUNK_SIZE, 128, dense positions per chunk; BUS_SIZE, 8, positions per write beat and per scan window; LANES, 2, matched pairs emitted per output beat; CHUNK_SIZE%BUS_SIZE==0 and 1<=LANES<=BUS_SIZE.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, sole clock.
- rst_ni, in, 1, asynchronous active-low reset.
- ifm_sparsemap_i, in, BUS_SIZE, nonzero map of one beat, bit k = position k.
- ifm_nonzero_data_i, in, BUS_SIZE*8, nonzero bytes packed from byte 0 in ascending position order.
- ifm_wr_valid_i / ifm_wr_ready_o, in/out, 1, IFM write handshake.
- filter_sparsemap_i, filter_nonzero_data_i, filter_wr_valid_i / filter_wr_ready_o: same as the IFM ports, for the filter stream.
- ifm_data_o / filter_data_o, out, LANES*8, matched byte pairs, lane 0 in bits [7:0].
- lane_valid_o, out, LANES, per-lane pair valid.
- data_valid_o / data_ready_i, out/in, 1, output beat handshake.
- chunk_end_o, out, 1, qualified by data_valid_o; marks the last beat of a chunk.

Function
REQ-003 States SHALL be FILL, SCAN. Reset enters FILL; FILL->SCAN when both streams have delivered CHUNK_SIZE/BUS_SIZE beats; SCAN->FILL on the transfer carrying chunk_end_o.
REQ-004 In FILL, x_wr_ready_o SHALL be 1 while that stream's beat count < CHUNK_SIZE/BUS_SIZE and 0 otherwise; both SHALL be 0 in SCAN.
REQ-005 A write SHALL occur on valid&&ready. Byte j of the beat SHALL be stored at the position of the (j+1)-th set map bit; zero positions SHALL store 0x00.
REQ-006 SCAN SHALL process windows 0..CHUNK_SIZE/BUS_SIZE-1 in order, using match mask = ifm_map & filter_map of the window.
REQ-007 Each output beat SHALL carry the lowest min(LANES, popcount) remaining mask bits in ascending order, lane i = i-th lowest. Emitted bits SHALL be cleared. The window SHALL advance when its mask becomes zero.
REQ-008 A non-final window whose mask is zero SHALL be skipped in exactly one cycle with no output beat.
REQ-009 The beat that empties the final window SHALL assert chunk_end_o. If the final window's mask is zero on arrival, one beat with lane_valid_o=0 and chunk_end_o=1 SHALL be emitted.
REQ-010 Outputs SHALL be registered. The first beat SHALL appear no earlier than 1 cycle after entering SCAN. At most one beat SHALL be emitted per cycle under continuous data_ready_i.
REQ-011 While data_valid_o&&!data_ready_i, all output ports SHALL hold stable.
REQ-012 Inactive lanes SHALL drive 0x00 on both data buses.

Reset
REQ-013 rst_ni low SHALL asynchronously clear the state to FILL, beat counts, window index and masks. Outputs SHALL then read: data_valid_o=0, chunk_end_o=0, lane_valid_o=0, data buses 0, wr_ready_o=0.
REQ-014 wr_ready_o SHALL rise in the first cycle after reset release.
REQ-015 Reset mid-FILL or mid-SCAN SHALL discard the partial chunk. Stored data bytes need not be cleared.

Configuration
REQ-016 Macro SPARSE_SEL_ACC_EN defined SHALL add outputs acc_o (out, 32) and acc_valid_o (out, 1):
- acc_o = unsigned sum of ifm*filter over all valid lanes of the chunk.
- acc_o is cleared on entry to SCAN.
- acc_valid_o pulses 1 cycle after the chunk_end_o transfer; acc_o holds until the next SCAN entry.
- Reset value of both outputs is 0.
REQ-017 Without SPARSE_SEL_ACC_EN, those ports and the accumulator logic SHALL be absent and all other behaviour SHALL be identical.

Verification (CHUNK_SIZE=16, BUS_SIZE=8, LANES=2, data_ready_i=1 unless stated)
REQ-018 Dense chunk: all maps 0xFF, IFM bytes 1..16, filter bytes all 2 -> 8 beats, pairs (1,2),(2,2)...(16,2), chunk_end_o on beat 8; with ACC, acc_o=272.
REQ-019 Disjoint maps: IFM 0x55, filter 0xAA -> exactly one beat, lane_valid_o=00, chunk_end_o=1; with ACC, acc_o=0.
REQ-020 Compressed input: IFM beat0 map 0x81 with bytes {0x03,0x07}, beat1 map 0x00; filter maps 0xFF with bytes all 1 -> beat 1 = pairs (3,1),(7,1), lane_valid_o=11; beat 2 empty with chunk_end_o=1.
REQ-021 Backpressure: data_ready_i=0 for 5 cycles during the dense chunk -> outputs stable for those cycles; no pair is lost or duplicated.
REQ-022 Load skew: IFM sends 2 beats while filter is idle -> ifm_wr_ready_o=0, filter_wr_ready_o=1, state stays FILL until filter delivers 2 beats.
REQ-023 Reset mid-SCAN after beat 3 -> outputs zero immediately; after release, a fresh dense chunk yields the REQ-018 result exactly.
